// File: rtl/vga_plot_pkg.sv
// Shared raster timing defaults, configuration address map and total-length helpers
// for the VGA plot blocks.
package vga_plot_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 2;

  typedef enum logic [1:0] {
    CFG_SLOPE     = 2'd0,
    CFG_INTERCEPT = 2'd1,
    CFG_COLOR     = 2'd2,
    CFG_ENABLE    = 2'd3
  } cfg_addr_e;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-tick divider, x/y counters, raw active-low syncs,
// active-area flag, frame-start pulse and the shadow-to-active commit strobe.
module vga_timing
  import vga_plot_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic       clk50_i,
  input  logic       reset_i,
  output logic       tick_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       in_display_o,
  output logic       frame_start_o,
  output logic       commit_o
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk50_i) begin
    if (reset_i) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tick_o        = tick;
    x_o           = x_q;
    y_o           = y_q;
    hsync_raw_o   = !((x_q >= HS_START) && (x_q < HS_END));
    vsync_raw_o   = !((y_q >= VS_START) && (y_q < VS_END));
    in_display_o  = (x_q < X_ACT) && (y_q < Y_ACT);
    frame_start_o = !reset_i && tick && (x_q == '0) && (y_q == '0);
    // Commit lands on the first blanking line so a whole visible frame uses one config.
    commit_o      = !reset_i && tick && (x_q == '0) && (y_q == Y_ACT);
  end

endmodule

// File: rtl/vga_line_plotter.sv
// Multi-channel line plotter: draws y = slope*x + intercept per channel using
// incremental accumulators, double-buffered config and a fixed-priority colour mux.
module vga_line_plotter
  import vga_plot_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned COLOR_W  = 3
) (
  input  logic                                            clk50,
  input  logic                                            reset,
  input  logic                                            cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                      cfg_addr,
  input  logic [WORD_W-1:0]                               cfg_wdata,
  output logic                                            hsync,
  output logic                                            vsync,
  output logic [COLOR_W-1:0]                              pix,
  output logic                                            in_display,
  output logic [9:0]                                      counter_x,
  output logic [9:0]                                      counter_y,
  output logic                                            frame_start
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic       tick;
  logic       commit;
  logic       hs_raw;
  logic       vs_raw;
  logic       disp_raw;
  logic [9:0] cx;
  logic [9:0] cy;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk50_i      (clk50),
    .reset_i      (reset),
    .tick_o       (tick),
    .x_o          (cx),
    .y_o          (cy),
    .hsync_raw_o  (hs_raw),
    .vsync_raw_o  (vs_raw),
    .in_display_o (disp_raw),
    .frame_start_o(frame_start),
    .commit_o     (commit)
  );

  logic [CHANNELS-1:0]              hit;
  logic [CHANNELS-1:0][COLOR_W-1:0] color_act;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WORD_W-1:0]  slope_sh_q;
    logic [WORD_W-1:0]  icpt_sh_q;
    logic [COLOR_W-1:0] color_sh_q;
    logic               en_sh_q;
    logic [WORD_W-1:0]  slope_q;
    logic [WORD_W-1:0]  icpt_q;
    logic [COLOR_W-1:0] color_q;
    logic               en_q;
    logic [WORD_W-1:0]  acc_q;
    logic [WORD_W-1:0]  cur;
    logic               wr_sel;

    assign wr_sel = cfg_we && (cfg_ch == CH_W'(g));

    always_ff @(posedge clk50) begin
      if (reset) begin
        slope_sh_q <= '0;
        icpt_sh_q  <= '0;
        color_sh_q <= '0;
        en_sh_q    <= 1'b0;
        slope_q    <= '0;
        icpt_q     <= '0;
        color_q    <= '0;
        en_q       <= 1'b0;
        acc_q      <= '0;
      end else begin
        if (wr_sel) begin
          case (cfg_addr_e'(cfg_addr))
            CFG_SLOPE:     slope_sh_q <= cfg_wdata;
            CFG_INTERCEPT: icpt_sh_q  <= cfg_wdata;
            CFG_COLOR:     color_sh_q <= cfg_wdata[COLOR_W-1:0];
            CFG_ENABLE:    en_sh_q    <= cfg_wdata[0];
          endcase
        end
        if (commit) begin
          slope_q <= slope_sh_q;
          icpt_q  <= icpt_sh_q;
          color_q <= color_sh_q;
          en_q    <= en_sh_q;
        end
        // acc_q holds intercept + slope*x for the current x once x > 0.
        if (tick) acc_q <= ((cx == '0) ? icpt_q : acc_q) + slope_q;
      end
    end

    // At x = 0 acc_q still carries the previous line's end value, so use the intercept.
    assign cur          = (cx == '0) ? icpt_q : acc_q;
    assign hit[g]       = en_q && (cur == WORD_W'(cy));
    assign color_act[g] = color_q;
  end

  logic [CHANNELS-1:0] hit_q;
  logic                disp_q;
  logic                hs1_q;
  logic                vs1_q;
  logic [COLOR_W-1:0]  pix_q;
  logic                hsync_q;
  logic                vsync_q;
  logic [COLOR_W-1:0]  sel_color;
  logic                found;

  always_comb begin
    sel_color = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!found && hit_q[i]) begin
        sel_color = color_act[i];
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      hit_q   <= '0;
      disp_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      pix_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (tick) begin
      hit_q   <= hit;
      disp_q  <= disp_raw;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
      pix_q   <= disp_q ? sel_color : '0;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign counter_x  = cx;
  assign counter_y  = cy;
  assign in_display = disp_q;
  assign pix        = pix_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;

endmodule

// File: tb/tb_vga_line_plotter.sv
// Bench for vga_line_plotter: a reduced raster instance for functional checks and a
// default-timing instance for the full-size sync periods.
module tb_vga_line_plotter;
  import vga_plot_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int NPOS = HT * VT;
  localparam int WAIT_LIMIT = 2000;
  localparam int MEAS_LIMIT = 8000;

  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        hsync, vsync, in_display, frame_start;
  logic [2:0]  pix;
  logic [9:0]  counter_x, counter_y;

  logic        d_cfg_we = 1'b0;
  logic [1:0]  d_cfg_ch = '0;
  logic [1:0]  d_cfg_addr = '0;
  logic [15:0] d_cfg_wdata = '0;
  logic        d_hsync, d_vsync, d_in_display, d_frame_start;
  logic [2:0]  d_pix;
  logic [9:0]  d_counter_x, d_counter_y;

  vga_line_plotter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(2), .CHANNELS(3), .WORD_W(16), .COLOR_W(3)
  ) dut (
    .clk50(clk50), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .hsync(hsync), .vsync(vsync),
    .pix(pix), .in_display(in_display), .counter_x(counter_x),
    .counter_y(counter_y), .frame_start(frame_start)
  );

  vga_line_plotter dut_def (
    .clk50(clk50), .reset(reset), .cfg_we(d_cfg_we), .cfg_ch(d_cfg_ch),
    .cfg_addr(d_cfg_addr), .cfg_wdata(d_cfg_wdata), .hsync(d_hsync), .vsync(d_vsync),
    .pix(d_pix), .in_display(d_in_display), .counter_x(d_counter_x),
    .counter_y(d_counter_y), .frame_start(d_frame_start)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] m_slope [3];
  logic [15:0] m_icpt  [3];
  logic [2:0]  m_col   [3];
  logic        m_en    [3];

  typedef struct {
    int phase;
    int x;
    int y;
    int exp_pix;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, got no event expected event", name);
  endtask

  function automatic int model_pix(input int x, input int y);
    logic [15:0] acc;
    if (x >= HA || y >= VA) return 0;
    for (int c = 0; c < 3; c++) begin
      acc = 16'(int'(m_icpt[c]) + int'(m_slope[c]) * x);
      if (m_en[c] && acc == 16'(y)) return int'(m_col[c]);
    end
    return 0;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return d_hsync;
      1:       return hsync;
      default: return vsync;
    endcase
  endfunction

  task automatic wait_pos(input int x, input int y);
    int n = 0;
    @(negedge clk50);
    while (!(int'(counter_x) == x && int'(counter_y) == y) && n < WAIT_LIMIT) begin
      @(negedge clk50);
      n++;
    end
    if (n >= WAIT_LIMIT) timeout($sformatf("wait_pos(%0d,%0d)", x, y));
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] addr, input int data);
    @(negedge clk50);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_addr  = addr;
    cfg_wdata = 16'(data);
    @(negedge clk50);
    cfg_we    = 1'b0;
  endtask

  // pix for raster position (x,y) is visible while the counters are two ticks further on
  task automatic probe(input string name, input int x, input int y, input int exp);
    int px = x + 2;
    int py = y;
    if (px >= HT) begin
      px -= HT;
      py = (py + 1) % VT;
    end
    wait_pos(px, py);
    check(name, int'(pix), exp);
  endtask

  task automatic run_phase(input int ph);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == ph)
        probe($sformatf("ph%0d_pix(%0d,%0d)", ph, vecs[i].x, vecs[i].y),
              vecs[i].x, vecs[i].y, vecs[i].exp_pix);
    end
  endtask

  task automatic scan_frame(input string name);
    wait_pos(2, 0);
    for (int i = 0; i < NPOS; i++) begin
      int p, q, sx, sy, q1;
      p  = int'(counter_y) * HT + int'(counter_x);
      q  = (p + NPOS - 2) % NPOS;
      sx = q % HT;
      sy = q / HT;
      q1 = (p + NPOS - 1) % NPOS;
      check($sformatf("%s_pix(%0d,%0d)", name, sx, sy), int'(pix), model_pix(sx, sy));
      check($sformatf("%s_hsync(%0d,%0d)", name, sx, sy), int'(hsync),
            (sx >= HA + HF && sx < HA + HF + HS) ? 0 : 1);
      check($sformatf("%s_vsync(%0d,%0d)", name, sx, sy), int'(vsync),
            (sy >= VA + VF && sy < VA + VF + VS) ? 0 : 1);
      check($sformatf("%s_disp(%0d,%0d)", name, sx, sy), int'(in_display),
            ((q1 % HT) < HA && (q1 / HT) < VA) ? 1 : 0);
      repeat (2) @(negedge clk50);
    end
  endtask

  task automatic measure(input string name, input int sel, input int exp_low, input int exp_per);
    int guard = 0;
    int nlow = 0;
    int nper = 0;
    @(negedge clk50);
    while (!sig(sel) && guard < MEAS_LIMIT) begin @(negedge clk50); guard++; end
    while (sig(sel) && guard < MEAS_LIMIT) begin @(negedge clk50); guard++; end
    while (!sig(sel) && guard < MEAS_LIMIT) begin @(negedge clk50); guard++; nlow++; end
    nper = nlow;
    while (sig(sel) && guard < MEAS_LIMIT) begin @(negedge clk50); guard++; nper++; end
    if (guard >= MEAS_LIMIT) timeout(name);
    else begin
      check({name, "_low_cycles"}, nlow, exp_low);
      check({name, "_period_cycles"}, nper, exp_per);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_slope[c] = '0;
      m_icpt[c]  = '0;
      m_col[c]   = '0;
      m_en[c]    = 1'b0;
    end
  endtask

  initial begin
    // phase 0: ch0 slope 2 colour 5
    vecs.push_back('{0, 0, 0, 5});
    vecs.push_back('{0, 1, 2, 5});
    vecs.push_back('{0, 2, 5, 0});
    vecs.push_back('{0, 5, 10, 5});
    vecs.push_back('{0, 6, 11, 0});
    vecs.push_back('{0, 15, 11, 0});
    // phase 1: ch0 and ch1 on the same diagonal, ch0 wins
    vecs.push_back('{1, 0, 0, 1});
    vecs.push_back('{1, 3, 3, 1});
    vecs.push_back('{1, 3, 4, 0});
    vecs.push_back('{1, 11, 11, 1});
    vecs.push_back('{1, 12, 11, 0});
    // phase 2: ch0 disabled, ch1 shows through
    vecs.push_back('{2, 0, 0, 2});
    vecs.push_back('{2, 5, 5, 2});
    vecs.push_back('{2, 5, 6, 0});
    vecs.push_back('{2, 11, 11, 2});
    // phase 3: ch2 slope -1 intercept 11, negative accumulator never hits
    vecs.push_back('{3, 11, 0, 6});
    vecs.push_back('{3, 12, 0, 0});
    vecs.push_back('{3, 15, 0, 0});
    vecs.push_back('{3, 5, 5, 0});
    vecs.push_back('{3, 5, 6, 6});
    vecs.push_back('{3, 0, 11, 6});
    // phase 4: same frame as a mid-frame colour write keeps the old colour
    vecs.push_back('{4, 5, 6, 6});
    vecs.push_back('{4, 2, 9, 6});
    // phase 5: next frame shows the new colour
    vecs.push_back('{5, 11, 0, 3});
    vecs.push_back('{5, 5, 6, 3});
    // phase 6: write in the commit cycle is not yet visible
    vecs.push_back('{6, 11, 0, 3});
    vecs.push_back('{6, 0, 11, 3});
    // phase 7: it appears one frame later
    vecs.push_back('{7, 11, 0, 4});
    vecs.push_back('{7, 3, 8, 4});

    model_clear();

    repeat (5) @(negedge clk50);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_pix", int'(pix), 0);
    check("rst_x", int'(counter_x), 0);
    check("rst_y", int'(counter_y), 0);
    check("rst_in_display", int'(in_display), 0);
    check("rst_frame_start", int'(frame_start), 0);
    reset = 1'b0;
    @(negedge clk50);
    check("post_rst1_x", int'(counter_x), 0);
    check("post_rst1_frame_start", int'(frame_start), 1);
    @(negedge clk50);
    check("post_rst2_x", int'(counter_x), 1);
    check("post_rst2_def_x", int'(d_counter_x), 1);
    check("post_rst2_frame_start", int'(frame_start), 0);

    measure("def_hsync", 0, 192, 1600);
    measure("small_hsync", 1, HS * 2, HT * 2);
    measure("small_vsync", 2, VS * HT * 2, NPOS * 2);

    // scenario A
    cfg_write(0, CFG_SLOPE, 2);
    cfg_write(0, CFG_INTERCEPT, 0);
    cfg_write(0, CFG_COLOR, 5);
    cfg_write(0, CFG_ENABLE, 1);
    cfg_write(3, CFG_ENABLE, 1);
    wait_pos(0, VA + 1);
    m_slope[0] = 16'd2; m_col[0] = 3'd5; m_en[0] = 1'b1;
    run_phase(0);
    scan_frame("A");

    // scenario B
    cfg_write(0, CFG_SLOPE, 1);
    cfg_write(0, CFG_COLOR, 1);
    cfg_write(1, CFG_SLOPE, 1);
    cfg_write(1, CFG_COLOR, 2);
    cfg_write(1, CFG_ENABLE, 1);
    wait_pos(0, VA + 1);
    m_slope[0] = 16'd1; m_col[0] = 3'd1;
    m_slope[1] = 16'd1; m_col[1] = 3'd2; m_en[1] = 1'b1;
    run_phase(1);
    cfg_write(0, CFG_ENABLE, 0);
    wait_pos(0, VA + 1);
    m_en[0] = 1'b0;
    run_phase(2);

    // scenario C
    cfg_write(1, CFG_ENABLE, 0);
    cfg_write(2, CFG_SLOPE, 16'hFFFF);
    cfg_write(2, CFG_INTERCEPT, VA - 1);
    cfg_write(2, CFG_COLOR, 6);
    cfg_write(2, CFG_ENABLE, 1);
    wait_pos(0, VA + 1);
    m_en[1] = 1'b0;
    m_slope[2] = 16'hFFFF; m_icpt[2] = 16'(VA - 1); m_col[2] = 3'd6; m_en[2] = 1'b1;
    run_phase(3);
    scan_frame("C");

    // mid-frame colour write, then a write landing exactly in the commit cycle
    wait_pos(0, 5);
    cfg_write(2, CFG_COLOR, 3);
    run_phase(4);
    wait_pos(0, VA + 1);
    run_phase(5);
    wait_pos(0, VA);
    cfg_write(2, CFG_COLOR, 4);
    run_phase(6);
    run_phase(7);

    // reset mid-frame clears raster, pipeline and configuration
    wait_pos(10, 5);
    reset = 1'b1;
    @(negedge clk50);
    check("midrst_x", int'(counter_x), 0);
    check("midrst_y", int'(counter_y), 0);
    check("midrst_hsync", int'(hsync), 1);
    check("midrst_vsync", int'(vsync), 1);
    check("midrst_pix", int'(pix), 0);
    check("midrst_in_display", int'(in_display), 0);
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    model_clear();
    scan_frame("R");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
